// File: rtl/x_micro_loader_if.sv
// Host/sequencer-facing bus of x_micro_loader: RX byte strobe, TX byte handshake,
// and the sequencer program/start/readback signals.
interface x_micro_loader_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_start;
    logic        i_busy;
    logic        o_wen;
    logic [3:0]  o_wcmd;
    logic [35:0] o_wdata;
    logic [8:0]  o_waddr;
    logic [35:0] i_data;
    logic        o_err;

    modport master (
        output i_rx_valid, i_rx_data, i_tx_ready, i_busy, i_data,
        input  o_tx_valid, o_tx_data, o_start, o_wen, o_wcmd, o_wdata, o_waddr, o_err
    );

    modport slave (
        input  i_rx_valid, i_rx_data, i_tx_ready, i_busy, i_data,
        output o_tx_valid, o_tx_data, o_start, o_wen, o_wcmd, o_wdata, o_waddr, o_err
    );
endinterface

// File: rtl/x_micro_loader.sv
// Byte-stream command parser feeding x_micro_sequencer: WRITE/START/READ frames,
// inter-byte timeout, error pulses and 5-byte readback over a valid/ready TX port.
module x_micro_loader #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    x_micro_loader_if.slave bus
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RCAP, RDOUT} state_t;

    state_t        state;
    logic [2:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    cmd_q;
    logic [8:0]    addr_q;
    logic [35:0]   data_q;
    logic [35:0]   rd_sh;
    logic          timed_out;

    assign timed_out = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            cmd_q          <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            rd_sh          <= '0;
            bus.o_tx_valid <= 1'b0;
            bus.o_tx_data  <= '0;
            bus.o_start    <= 1'b0;
            bus.o_wen      <= 1'b0;
            bus.o_wcmd     <= '0;
            bus.o_wdata    <= '0;
            bus.o_waddr    <= '0;
            bus.o_err      <= 1'b0;
        end else begin
            bus.o_start <= 1'b0;
            bus.o_wen   <= 1'b0;
            bus.o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_rx_valid) begin
                        if (bus.i_rx_data[7:4] == 4'hA) begin
                            cmd_q    <= bus.i_rx_data[3:0];
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            state    <= ADDR;
                        end else if (bus.i_rx_data == 8'hB0) begin
                            bus.o_start <= ~bus.i_busy;
                            bus.o_err   <= bus.i_busy;
                        end else if (bus.i_rx_data == 8'hC0) begin
                            state <= RCAP;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                end
                ADDR, DATA: begin
                    // An arriving byte takes priority over an expiring timeout.
                    if (bus.i_rx_valid) begin
                        tmo_cnt <= '0;
                        if (state == ADDR) begin
                            addr_q <= {addr_q[0], bus.i_rx_data};
                            if (byte_cnt == 3'd1) begin
                                byte_cnt <= '0;
                                state    <= DATA;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                            end
                        end else begin
                            data_q <= {data_q[27:0], bus.i_rx_data};
                            if (byte_cnt == 3'd4) begin
                                byte_cnt <= '0;
                                state    <= IDLE;
                                if (bus.i_busy) begin
                                    bus.o_err <= 1'b1;
                                end else begin
                                    bus.o_wen   <= 1'b1;
                                    bus.o_wcmd  <= cmd_q;
                                    bus.o_waddr <= addr_q;
                                    bus.o_wdata <= {data_q[27:0], bus.i_rx_data};
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                            end
                        end
                    end else if (timed_out) begin
                        bus.o_err <= 1'b1;
                        byte_cnt  <= '0;
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RCAP: begin
                    if (bus.i_rx_valid) bus.o_err <= 1'b1;
                    rd_sh          <= bus.i_data;
                    bus.o_tx_valid <= 1'b1;
                    bus.o_tx_data  <= {4'h0, bus.i_data[35:32]};
                    byte_cnt       <= '0;
                    state          <= RDOUT;
                end
                RDOUT: begin
                    if (bus.i_rx_valid) bus.o_err <= 1'b1;
                    if (bus.o_tx_valid && bus.i_tx_ready) begin
                        if (byte_cnt == 3'd4) begin
                            bus.o_tx_valid <= 1'b0;
                            byte_cnt       <= '0;
                            state          <= IDLE;
                        end else begin
                            // rd_sh[31:24] always holds the next byte after the nibble-led first one.
                            bus.o_tx_data <= rd_sh[31:24];
                            rd_sh         <= {rd_sh[27:0], 8'h00};
                            byte_cnt      <= byte_cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x_micro_loader.sv
// Randomized self-checking bench for x_micro_loader against a frame-level reference model.
module tb_x_micro_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;

    x_micro_loader_if bus ();

    x_micro_loader #(.TIMEOUT(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event monitor: counts pulses and records TX handshakes and TX stall violations.
    int          err_cnt = 0;
    int          start_cnt = 0;
    int          wen_cnt = 0;
    int          stab_viol = 0;
    logic [7:0]  txq[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.o_err === 1'b1) err_cnt++;
            if (bus.o_start === 1'b1) start_cnt++;
            if (bus.o_wen === 1'b1) wen_cnt++;
            if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) txq.push_back(bus.o_tx_data);
            if (prev_stall && (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== prev_data)) stab_viol++;
            prev_stall = (bus.o_tx_valid === 1'b1) && (bus.i_tx_ready !== 1'b1);
            prev_data  = bus.o_tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = $urandom;
        repeat (gap) tick();
    endtask

    // Sends a WRITE frame; busy applies to the last byte, which is followed by no gap.
    task automatic send_write(input logic [7:0] fb [8], input logic busy, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            bus.i_busy = (i == 7) ? busy : 1'($urandom);
            send_byte(fb[i], (i == 7) ? 0 : int'($urandom_range(maxgap, 0)));
        end
        bus.i_busy = 1'b0;
    endtask

    // Builds WRITE frame bytes from fields, filling ignored bits with noise.
    task automatic make_write(input logic [3:0] c, input logic [8:0] a, input logic [35:0] d,
                              output logic [7:0] fb [8]);
        fb[0] = 8'hA0 + 8'(c);
        fb[1] = 8'(($urandom % 128) * 2 + a / 256);
        fb[2] = 8'(a % 256);
        fb[3] = 8'(($urandom % 16) * 16 + d / 36'h100000000);
        fb[4] = 8'(d / 36'h1000000);
        fb[5] = 8'(d / 36'h10000);
        fb[6] = 8'(d / 36'h100);
        fb[7] = 8'(d);
    endtask

    task automatic test_reset();
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'hA5;
        bus.i_tx_ready = 1'b1;
        bus.i_busy     = 1'b0;
        bus.i_data     = '0;
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.o_tx_valid, bus.o_tx_data, bus.o_start, bus.o_wen, bus.o_wcmd,
             bus.o_wdata, bus.o_waddr, bus.o_err} !== 61'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tx_valid=%b wen=%b err=%b wcmd=%h wdata=%h waddr=%h, want all 0",
                     bus.o_tx_valid, bus.o_wen, bus.o_err, bus.o_wcmd, bus.o_wdata, bus.o_waddr);
        end
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [7:0]  fb [8];
        logic [3:0]  ec;
        logic [8:0]  ea;
        logic [35:0] ed;
        int          e0;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin
                fb = '{8'hA3, 8'h01, 8'h2C, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
                ec = 4'h3; ea = 9'h12C; ed = 36'h512345678;
            end else begin
                ec = 4'($urandom);
                ea = 9'($urandom);
                ed = 36'($urandom) * 36'h10 + 36'($urandom % 16);
                make_write(ec, ea, ed, fb);
            end
            e0 = err_cnt;
            send_write(fb, 1'b0, 3);
            n_cmp++;
            if (bus.o_wen !== 1'b1 || bus.o_wcmd !== ec || bus.o_waddr !== ea || bus.o_wdata !== ed) begin
                n_bad++;
                $display("FAIL write_emit[%0d]: got wen=%b cmd=%h addr=%h data=%h, want wen=1 cmd=%h addr=%h data=%h",
                         n, bus.o_wen, bus.o_wcmd, bus.o_waddr, bus.o_wdata, ec, ea, ed);
            end
            tick();
            n_cmp++;
            if (bus.o_wen !== 1'b0 || bus.o_wdata !== ed || bus.o_waddr !== ea || err_cnt != e0) begin
                n_bad++;
                $display("FAIL write_hold[%0d]: got wen=%b data=%h addr=%h errs=%0d, want wen=0 data=%h addr=%h errs=0",
                         n, bus.o_wen, bus.o_wdata, bus.o_waddr, err_cnt - e0, ed, ea);
            end
        end
    endtask

    task automatic test_write_busy();
        logic [7:0]  fb [8];
        logic [3:0]  pc;
        logic [8:0]  pa;
        logic [35:0] pd;
        int          e0, w0;
        pc = bus.o_wcmd; pa = bus.o_waddr; pd = bus.o_wdata;
        make_write(4'($urandom), 9'($urandom), 36'($urandom), fb);
        e0 = err_cnt; w0 = wen_cnt;
        send_write(fb, 1'b1, 2);
        tick();
        tick();
        n_cmp++;
        if (wen_cnt != w0 || err_cnt != e0 + 1 || bus.o_wcmd !== pc || bus.o_waddr !== pa || bus.o_wdata !== pd) begin
            n_bad++;
            $display("FAIL write_busy: got wens=%0d errs=%0d data=%h, want wens=0 errs=1 data=%h",
                     wen_cnt - w0, err_cnt - e0, bus.o_wdata, pd);
        end
    endtask

    task automatic test_start();
        int e0;
        bus.i_busy = 1'b0;
        e0 = err_cnt;
        send_byte(8'hB0, 0);
        n_cmp++;
        if (bus.o_start !== 1'b1 || bus.o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL start_idle: got start=%b err=%b, want start=1 err=0", bus.o_start, bus.o_err);
        end
        tick();
        n_cmp++;
        if (bus.o_start !== 1'b0) begin
            n_bad++;
            $display("FAIL start_pulse_width: got start=%b, want 0", bus.o_start);
        end
        bus.i_busy = 1'b1;
        send_byte(8'hB0, 0);
        bus.i_busy = 1'b0;
        n_cmp++;
        if (bus.o_start !== 1'b0 || bus.o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL start_busy: got start=%b err=%b, want start=0 err=1", bus.o_start, bus.o_err);
        end
        tick();
        n_cmp++;
        if (bus.o_err !== 1'b0 || err_cnt != e0 + 1) begin
            n_bad++;
            $display("FAIL start_busy_err_width: got err=%b errs=%0d, want err=0 errs=1", bus.o_err, err_cnt - e0);
        end
    endtask

    task automatic test_read(input logic inject);
        logic [35:0] d;
        logic [7:0]  exp [5];
        int          e0, s0, v0;
        for (int rep = 0; rep < 4; rep++) begin
            d = (rep == 0) ? 36'hABCDEF012 : 36'($urandom) * 36'h10 + 36'($urandom % 16);
            exp[0] = 8'(d / 36'h100000000);
            for (int k = 1; k < 5; k++) exp[k] = 8'(d >> (8 * (4 - k)));
            bus.i_data = d;
            txq.delete();
            e0 = err_cnt; s0 = start_cnt; v0 = stab_viol;
            send_byte(8'hC0, 0);
            for (int c = 0; c < 300 && txq.size() < 5; c++) begin
                bus.i_tx_ready = ($urandom % 3 == 0);
                bus.i_rx_valid = inject && (c == 2);
                bus.i_rx_data  = 8'hB0;
                tick();
            end
            bus.i_rx_valid = 1'b0;
            bus.i_tx_ready = 1'b0;
            tick();
            n_cmp++;
            if (txq.size() != 5 || bus.o_tx_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL read_count[%0d]: got bytes=%0d tx_valid=%b, want bytes=5 tx_valid=0",
                         rep, txq.size(), bus.o_tx_valid);
            end
            for (int k = 0; k < 5 && k < txq.size(); k++) begin
                n_cmp++;
                if (txq[k] !== exp[k]) begin
                    n_bad++;
                    $display("FAIL read_byte[%0d][%0d]: got %h, want %h", rep, k, txq[k], exp[k]);
                end
            end
            n_cmp++;
            if (stab_viol != v0 || err_cnt != e0 + int'(inject) || start_cnt != s0) begin
                n_bad++;
                $display("FAIL read_side[%0d]: got stall_viol=%0d errs=%0d starts=%0d, want 0 %0d 0",
                         rep, stab_viol - v0, err_cnt - e0, start_cnt - s0, int'(inject));
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0]  fb [8];
        logic [3:0]  ec;
        logic [8:0]  ea;
        logic [35:0] ed;
        int          first, w0;
        w0 = wen_cnt;
        first = -1;
        send_byte(8'hA1, 0);
        send_byte(8'h00, 0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.o_err === 1'b1 && first < 0) first = k;
        end
        n_cmp++;
        if (first != 16 || wen_cnt != w0) begin
            n_bad++;
            $display("FAIL timeout: got err at idle cycle %0d wens=%0d, want cycle 16 wens=0", first, wen_cnt - w0);
        end
        ec = 4'($urandom); ea = 9'($urandom); ed = 36'($urandom) * 36'h10 + 36'($urandom % 16);
        make_write(ec, ea, ed, fb);
        send_write(fb, 1'b0, 6);
        n_cmp++;
        if (bus.o_wen !== 1'b1 || bus.o_wcmd !== ec || bus.o_waddr !== ea || bus.o_wdata !== ed) begin
            n_bad++;
            $display("FAIL timeout_recover: got wen=%b cmd=%h addr=%h data=%h, want 1 %h %h %h",
                     bus.o_wen, bus.o_wcmd, bus.o_waddr, bus.o_wdata, ec, ea, ed);
        end
        tick();
    endtask

    task automatic test_bad_cmd();
        logic [7:0] bad;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) bad = 8'h7F;
            else begin
                bad = 8'($urandom);
                while (bad[7:4] == 4'hA || bad == 8'hB0 || bad == 8'hC0) bad = 8'($urandom);
            end
            send_byte(bad, 0);
            n_cmp++;
            if (bus.o_err !== 1'b1) begin
                n_bad++;
                $display("FAIL bad_cmd[%02h]: got err=%b, want 1", bad, bus.o_err);
            end
            send_byte(8'hB0, 0);
            n_cmp++;
            if (bus.o_err !== 1'b0 || bus.o_start !== 1'b1) begin
                n_bad++;
                $display("FAIL bad_cmd_idle[%02h]: got err=%b start=%b, want err=0 start=1", bad, bus.o_err, bus.o_start);
            end
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  fb [8];
        logic [3:0]  ec;
        logic [8:0]  ea;
        logic [35:0] ed;
        make_write(4'($urandom), 9'($urandom), 36'($urandom), fb);
        for (int i = 0; i < 4; i++) send_byte(fb[i], 0);
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.o_tx_valid, bus.o_tx_data, bus.o_start, bus.o_wen, bus.o_wcmd,
             bus.o_wdata, bus.o_waddr, bus.o_err} !== 61'd0) begin
            n_bad++;
            $display("FAIL reset_midframe: got wcmd=%h wdata=%h waddr=%h wen=%b err=%b, want all 0",
                     bus.o_wcmd, bus.o_wdata, bus.o_waddr, bus.o_wen, bus.o_err);
        end
        rst = 1'b1;
        tick();
        ec = 4'($urandom); ea = 9'($urandom); ed = 36'($urandom) * 36'h10 + 36'($urandom % 16);
        make_write(ec, ea, ed, fb);
        send_write(fb, 1'b0, 2);
        n_cmp++;
        if (bus.o_wen !== 1'b1 || bus.o_wcmd !== ec || bus.o_waddr !== ea || bus.o_wdata !== ed) begin
            n_bad++;
            $display("FAIL reset_recover: got wen=%b cmd=%h addr=%h data=%h, want 1 %h %h %h",
                     bus.o_wen, bus.o_wcmd, bus.o_waddr, bus.o_wdata, ec, ea, ed);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  fb [8];
        logic [3:0]  ec;
        logic [8:0]  ea;
        logic [35:0] ed;
        for (int n = 0; n < 3; n++) begin
            ec = 4'($urandom); ea = 9'($urandom); ed = 36'($urandom) * 36'h10 + 36'($urandom % 16);
            make_write(ec, ea, ed, fb);
            send_write(fb, 1'b0, 0);
            n_cmp++;
            if (bus.o_wen !== 1'b1 || bus.o_wcmd !== ec || bus.o_waddr !== ea || bus.o_wdata !== ed) begin
                n_bad++;
                $display("FAIL b2b_write[%0d]: got wen=%b cmd=%h addr=%h data=%h, want 1 %h %h %h",
                         n, bus.o_wen, bus.o_wcmd, bus.o_waddr, bus.o_wdata, ec, ea, ed);
            end
            send_byte(8'hB0, 0);
            n_cmp++;
            if (bus.o_start !== 1'b1 || bus.o_wen !== 1'b0 || bus.o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_start[%0d]: got start=%b wen=%b err=%b, want 1 0 0",
                         n, bus.o_start, bus.o_wen, bus.o_err);
            end
        end
        tick();
    endtask

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        bus.i_tx_ready = 1'b0;
        bus.i_busy     = 1'b0;
        bus.i_data     = '0;
        #2;
        test_reset();
        test_write();
        test_write_busy();
        test_start();
        test_read(1'b0);
        test_read(1'b1);
        test_timeout();
        test_bad_cmd();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
